// File: rtl/contador_pkg.sv
// Shared encodings for contador_universal: count modes and ping-pong bounce states.
package contador_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } bounce_e;

endpackage

// File: rtl/contador_universal.sv
// Parametrised modulo-N counter with load, direction and wrap/saturate/ping-pong modes.
// Handshake-free block: every enabled clock is one step; tc and wrap are the only events downstream sees.
module contador_universal
    import contador_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int MODULO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             dir_o,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_params
        $error("contador_universal: illegal WIDTH/MODULO combination");
    end

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] BOUNCE_DOWN_Q = WIDTH'(MODULO - 2);
    localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    bounce_e          dir_q, dir_d;
    logic             wrap_q, wrap_d;

    mode_e            mode_s;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   up_ext;
    logic [WIDTH-1:0] load_clamped;

    assign mode_s = mode_e'(mode);
    assign q_ext  = {1'b0, q_q};
    // Increment is formed one bit wider so the bound check happens before truncation.
    assign up_ext = q_ext + ONE_EXT;
    assign load_clamped = ({1'b0, load_val} > MAX_EXT) ? MAX_Q : load_val;

    always_comb begin
        q_d    = q_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;

        // Outside ping-pong the effective direction simply tracks the input.
        if (mode_s != MODE_PINGPONG) begin
            dir_d = bounce_e'(dir);
        end

        if (load) begin
            q_d = load_clamped;
        end else if (en) begin
            case (mode_s)
                MODE_WRAP: begin
                    if (dir) begin
                        if (up_ext > MAX_EXT) begin
                            q_d    = '0;
                            wrap_d = 1'b1;
                        end else begin
                            q_d = up_ext[WIDTH-1:0];
                        end
                    end else begin
                        if (q_q == '0) begin
                            q_d    = MAX_Q;
                            wrap_d = 1'b1;
                        end else begin
                            q_d = q_q - ONE_Q;
                        end
                    end
                end
                MODE_SAT: begin
                    if (dir) begin
                        if (up_ext <= MAX_EXT) q_d = up_ext[WIDTH-1:0];
                    end else begin
                        if (q_q != '0) q_d = q_q - ONE_Q;
                    end
                end
                MODE_PINGPONG: begin
                    if (dir_q == ST_UP) begin
                        if (up_ext > MAX_EXT) begin
                            q_d    = BOUNCE_DOWN_Q;
                            dir_d  = ST_DOWN;
                            wrap_d = 1'b1;
                        end else begin
                            q_d = up_ext[WIDTH-1:0];
                        end
                    end else begin
                        if (q_q == '0) begin
                            q_d    = ONE_Q;
                            dir_d  = ST_UP;
                            wrap_d = 1'b1;
                        end else begin
                            q_d = q_q - ONE_Q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            dir_q  <= ST_UP;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
        end
    end

    assign q     = q_q;
    assign dir_o = dir_q;
    assign wrap  = wrap_q;
    assign tc    = en & ((dir_q == ST_UP) ? (q_q == MAX_Q) : (q_q == '0));

endmodule

// File: tb/tb_contador_universal.sv
// Directed scoreboard bench for contador_universal at WIDTH=3, MODULO=6.
module tb_contador_universal;

    localparam int WIDTH  = 3;
    localparam int MODULO = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             dir = 1'b1;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] q;
    logic             dir_o;
    logic             tc;
    logic             wrap;

    contador_universal #(.WIDTH(WIDTH), .MODULO(MODULO)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .dir(dir), .mode(mode), .q(q), .dir_o(dir_o), .tc(tc), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // {q, dir_o, wrap, tc} expected just after each edge
    logic [5:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic tc_of(input logic e, input logic [2:0] qv, input logic d);
        return e & (d ? (qv == 3'd5) : (qv == 3'd0));
    endfunction

    task automatic cyc(input logic r, input logic e, input logic l, input logic [2:0] lv,
                       input logic d, input logic [1:0] m,
                       input logic [2:0] eq, input logic ed, input logic ew);
        @(negedge clk);
        rst = r; en = e; load = l; load_val = lv; dir = d; mode = m;
        exp_q.push_back({eq, ed, ew, tc_of(e, eq, ed)});
        @(posedge clk);
    endtask

    // Monitor: checks the state produced by every edge for which stimulus was issued.
    always @(posedge clk) begin
        logic [5:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({q, dir_o, wrap, tc} !== e) begin
                n_fail++;
                $display("FAIL step%0d: got q=%0d dir_o=%b wrap=%b tc=%b, want q=%0d dir_o=%b wrap=%b tc=%b",
                         n_checks, q, dir_o, wrap, tc, e[5:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        cyc(1, 0, 0, 0, 1, 2'b00, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 2'b00, 0, 1, 0);
        // wrap up: 1,2,3,4,5,0,1,2 with wrap on the 5->0 edge
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 0, 0, 1, 2'b00, 3'(i % 6), 1, (i % 6) == 0);
        end
        // wrap down from reset: 5,4,3,2,1,0,5
        cyc(1, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 2'b00, 5, 0, 1);
        cyc(0, 1, 0, 0, 0, 2'b00, 4, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b00, 3, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b00, 2, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b00, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b00, 5, 0, 1);
        // saturate: load 4, count up to 5 and stick, then down to 0 and stick
        cyc(0, 0, 1, 4, 1, 2'b01, 4, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b01, 5, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b01, 5, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b01, 5, 1, 0);
        cyc(0, 1, 0, 0, 0, 2'b01, 4, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b01, 3, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b01, 2, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b01, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b01, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b01, 0, 0, 0);
        // ping-pong from reset: 1..5,4..0,1,2
        cyc(1, 0, 0, 0, 1, 2'b10, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 1, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 2, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 3, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 4, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 5, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 4, 0, 1);
        cyc(0, 1, 0, 0, 1, 2'b10, 3, 0, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 2, 0, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b10, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b10, 1, 1, 1);
        cyc(0, 1, 0, 0, 0, 2'b10, 2, 1, 0);
        // advance to DOWN at q=3, then reset mid-count and resume
        cyc(0, 1, 0, 0, 1, 2'b10, 3, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 4, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 5, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 4, 0, 1);
        cyc(0, 1, 0, 0, 1, 2'b10, 3, 0, 0);
        cyc(1, 1, 0, 0, 0, 2'b10, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 2'b10, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 2'b10, 2, 1, 0);
        // load clamps and overrides a simultaneous count
        cyc(0, 1, 1, 7, 1, 2'b00, 5, 1, 0);
        cyc(0, 1, 1, 2, 1, 2'b00, 2, 1, 0);
        cyc(0, 1, 0, 0, 1, 2'b00, 3, 1, 0);
        // hold mode tracks dir but keeps q; idle ping-pong keeps dir_o
        cyc(0, 1, 0, 0, 0, 2'b11, 3, 0, 0);
        cyc(0, 0, 0, 0, 1, 2'b10, 3, 0, 0);
        // entering ping-pong continues in the current DOWN direction
        cyc(0, 1, 0, 0, 1, 2'b10, 2, 0, 0);
        // load in ping-pong leaves the bounce state alone
        cyc(0, 1, 1, 5, 1, 2'b10, 5, 0, 0);
        cyc(0, 1, 0, 0, 1, 2'b10, 4, 0, 0);
        cyc(0, 0, 0, 0, 1, 2'b00, 4, 1, 0);

        @(negedge clk);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
